router_in_port_xy: RTL and testbench
====================================

Name: router_in_port_xy

Overview:
- Parametrised, clocked successor of the single-direction CSP input router.
- One instance sits on each input side (N/E/S/W) of a mesh NoC router.
- Buffers incoming spike packets in a FIFO, computes the XY route from the head packet, and updates the hop source coordinate.
- Presents the packet to exactly one of five outputs (N, E, S, W, PE) over valid/ready, and drops and flags illegal U-turn routes.

Parameters:
- WIDTH, 35: packet width in bits.
- COORD_W, 2: width of each coordinate field.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- IN_DIR, 2: arrival side of this port. Encoding 0=N, 1=E, 2=S, 3=W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream packet valid.
- in_data  in  WIDTH  upstream packet.
- in_ready  out  1  port can accept a packet.
- out_valid  out  5  one-hot; bit order 0=N, 1=E, 2=S, 3=W, 4=PE.
- out_data  out  WIDTH  routed packet, shared by all five outputs.
- out_ready  in  5  per-output downstream ready.
- route_err  out  1  one-cycle pulse when a packet is dropped.

Behaviour:
- Packet fields, MSB first:
  - src_x = [WIDTH-1 -: COORD_W]
  - src_y = next COORD_W bits
  - dst_x = next COORD_W bits
  - dst_y = next COORD_W bits
  - remaining bits are payload, carried unchanged.
- Reset (rst_n low at a rising edge):
  - FIFO emptied; output register invalidated.
  - out_valid=0, out_data=0, route_err=0, in_ready=0.
  - in_ready rises at the first edge with rst_n high.
  - Reset mid-operation discards all held packets, with no partial output.
- Input handshake:
  - Push when in_valid && in_ready at a rising edge.
  - in_ready is registered and equals !full for the next cycle.
  - A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
  - in_data is ignored when in_valid=0.
- Output stage (registered head): two states, EMPTY and HOLD.
  - EMPTY, FIFO non-empty: pop head, route it, load the output register, go to HOLD.
  - HOLD: the register stays stable until out_ready[sel] && out_valid[sel].
  - On that fire edge, if the FIFO is non-empty, pop and load the next packet in the same edge (throughput 1 packet/cycle). Otherwise go to EMPTY.
  - out_valid, out_data and sel must not change while HOLD is stalled.
  - out_ready bits other than sel are ignored.
- Latency: a packet pushed at edge k is visible on out_valid after edge k+1, provided the output stage is empty or firing at edge k+1.
- Route (XY order), evaluated on the head at load time:
  - dst_x>src_x: E, src_x+1.
  - dst_x<src_x: W, src_x-1.
  - Otherwise, dst_y>src_y: N, src_y+1.
  - Otherwise, dst_y<src_y: S, src_y-1.
  - Otherwise: PE, packet unchanged.
  - Arithmetic is COORD_W-bit modulo. The ordering comparisons guarantee no wrap occurs.
- Illegal route: the computed direction equals IN_DIR (U-turn).
  - The packet is popped and discarded, never loaded.
  - route_err=1 for exactly the following cycle; the output state is unchanged.
  - Consecutive illegal packets pulse route_err on consecutive cycles.
- Simultaneous push and pop on a non-full FIFO: both take effect; the occupancy is unchanged.
- Ordering: packets leave in arrival order; dropped packets are skipped.

Optional Feature:
- Macro: ROUTER_IN_PKT_CNT_EN.
- When defined:
  - Adds output port pkt_cnt [5*16-1:0]: five 16-bit counters, same bit order as out_valid.
  - Each counter increments on each fire of its output.
  - Counters saturate at 16'hFFFF and are cleared by reset.
  - Adds output drop_cnt [15:0], incremented on each route_err pulse, also saturating.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Straight route: IN_DIR=2, in_data src=(0,0) dst=(2,0), out_ready=5'b11111 → out_valid=5'b00010, out_data src_x=1, payload intact, out_valid asserted after edge k+1.
- PE delivery: src=(1,3) dst=(1,3) → out_valid=5'b10000, out_data identical to in_data.
- Backpressure: DEPTH=4, out_ready=0, push 6 packets → 1 loaded into the output register, 4 in the FIFO, in_ready=0. Then out_ready[sel]=1 → packets drain in order, 1 per cycle.
- U-turn drop: IN_DIR=2, src=(1,2) dst=(1,0) → no out_valid, route_err pulses 1 cycle; the next legal packet routes normally.
- Reset mid-stream: 3 packets buffered, out_valid=1, assert rst_n=0 for 1 edge → out_valid=0, in_ready=0, then in_ready=1 at the next edge; no stale packets emerge.
- Counters, ROUTER_IN_PKT_CNT_EN defined: 3 E packets and 1 U-turn packet → pkt_cnt[E]=3, drop_cnt=1, other counters 0.

Source files
------------

// File: rtl/router_in_port_xy.sv
// Mesh NoC input port: packet FIFO, XY route of the head packet into a registered output stage, U-turn drop.
// Optional per-output fire counters and drop counter when ROUTER_IN_PKT_CNT_EN is defined.
module router_in_port_xy #(
  parameter int WIDTH   = 35,
  parameter int COORD_W = 2,
  parameter int DEPTH   = 4,
  parameter int IN_DIR  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [4:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [4:0]       out_ready,
  output logic             route_err
`ifdef ROUTER_IN_PKT_CNT_EN
  ,
  output logic [5*16-1:0]  pkt_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam int SX = WIDTH - 1;
  localparam int SY = WIDTH - 1 - COORD_W;
  localparam int DX = WIDTH - 1 - 2*COORD_W;
  localparam int DY = WIDTH - 1 - 3*COORD_W;

  typedef enum logic {S_EMPTY, S_HOLD} state_e;
  typedef enum logic [2:0] {DIR_N = 3'd0, DIR_E = 3'd1, DIR_S = 3'd2, DIR_W = 3'd3, DIR_PE = 3'd4} dir_e;

  state_e state_q, state_d;
  dir_e   sel_q, sel_d, dir_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             route_err_q, route_err_d;

  logic             push, pop, load, drop, fire, illegal;
  logic             empty, full;
  logic [WIDTH-1:0] head, routed;
  logic [COORD_W-1:0] sx, sy, dx, dy;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_C);

  // XY route of the current FIFO head
  always_comb begin
    head   = mem_q[rptr_q];
    sx     = head[SX -: COORD_W];
    sy     = head[SY -: COORD_W];
    dx     = head[DX -: COORD_W];
    dy     = head[DY -: COORD_W];
    routed = head;
    dir_d  = DIR_PE;
    if (dx > sx) begin
      dir_d = DIR_E;
      routed[SX -: COORD_W] = sx + COORD_W'(1);
    end else if (dx < sx) begin
      dir_d = DIR_W;
      routed[SX -: COORD_W] = sx - COORD_W'(1);
    end else if (dy > sy) begin
      dir_d = DIR_N;
      routed[SY -: COORD_W] = sy + COORD_W'(1);
    end else if (dy < sy) begin
      dir_d = DIR_S;
      routed[SY -: COORD_W] = sy - COORD_W'(1);
    end
    illegal = (3'(dir_d) == 3'(IN_DIR));
  end

  always_comb begin
    push = in_valid && in_ready_q && !full;
    pop  = !empty && ((state_q == S_EMPTY) || fire);
    load = pop && !illegal;
    drop = pop && illegal;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + ONE_C;
      2'b01:   cnt_d = cnt_q - ONE_C;
      default: cnt_d = cnt_q;
    endcase
    in_ready_d  = (cnt_d != DEPTH_C);
    data_d      = load ? routed : data_q;
    sel_d       = load ? dir_d : sel_q;
    route_err_d = drop;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      data_q      <= '0;
      sel_q       <= DIR_PE;
      route_err_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      route_err_q <= route_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // A fire with a dropped or missing successor empties the output stage
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (load) state_d = S_HOLD;
      S_HOLD:  if (fire && !load) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_HOLD) ? (5'b00001 << sel_q) : '0;
    fire      = |(out_valid & out_ready);
    out_data  = data_q;
    route_err = route_err_q;
    in_ready  = in_ready_q;
  end

`ifdef ROUTER_IN_PKT_CNT_EN
  logic [15:0] pcnt_q [5];
  logic [15:0] dcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 5; i++) pcnt_q[i] <= '0;
      dcnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (fire && (3'(sel_q) == 3'(i)) && (pcnt_q[i] != '1)) pcnt_q[i] <= pcnt_q[i] + 16'd1;
      end
      if (route_err_q && (dcnt_q != '1)) dcnt_q <= dcnt_q + 16'd1;
    end
  end

  always_comb begin
    pkt_cnt = '0;
    for (int unsigned i = 0; i < 5; i++) pkt_cnt[16*i +: 16] = pcnt_q[i];
    drop_cnt = dcnt_q;
  end
`endif

endmodule

// File: tb/tb_router_in_port_xy.sv
// Bench for router_in_port_xy (default parameters, IN_DIR=2): queue-based reference model compared every cycle,
// plus directed vectors with literal expectations.
module tb_router_in_port_xy;
  localparam int W   = 35;
  localparam int D   = 4;
  localparam int IND = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [4:0]   out_valid;
  logic [W-1:0] out_data;
  logic [4:0]   out_ready;
  logic         route_err;
`ifdef ROUTER_IN_PKT_CNT_EN
  logic [79:0]  pkt_cnt;
  logic [15:0]  drop_cnt;
`endif

  router_in_port_xy #(.WIDTH(W), .COORD_W(2), .DEPTH(D), .IN_DIR(IND)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .route_err (route_err)
`ifdef ROUTER_IN_PKT_CNT_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic [1:0] sx, input logic [1:0] sy,
                                      input logic [1:0] dx, input logic [1:0] dy,
                                      input logic [26:0] pl);
    return {sx, sy, dx, dy, pl};
  endfunction

  // Route rule: direction 0=N 1=E 2=S 3=W 4=PE, with the hop source coordinate moved one step.
  function automatic void route(input logic [W-1:0] p, output int d, output logic [W-1:0] np);
    int sx, sy, dx, dy;
    sx = int'(p[34:33]); sy = int'(p[32:31]); dx = int'(p[30:29]); dy = int'(p[28:27]);
    np = p;
    if (dx > sx)      begin d = 1; np[34:33] = 2'(sx + 1); end
    else if (dx < sx) begin d = 3; np[34:33] = 2'(sx - 1); end
    else if (dy > sy) begin d = 0; np[32:31] = 2'(sy + 1); end
    else if (dy < sy) begin d = 2; np[32:31] = 2'(sy - 1); end
    else              d = 4;
  endfunction

  logic [W-1:0] mq[$];
  bit           hv;
  logic [W-1:0] hp;
  int           hd;
  bit           rdy_m, err_m, started;
  bit           m_push, m_fire;
  int           m_d;
  logic [W-1:0] m_p, m_np;

  initial begin
    started = 0; hv = 0; hd = 0; hp = '0; rdy_m = 0; err_m = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete(); hv = 0; hp = '0; rdy_m = 0; err_m = 0; started = 1;
    end else if (started) begin
      m_push = in_valid && rdy_m && (mq.size() < D);
      m_fire = hv && out_ready[hd];
      if (m_fire) hv = 0;
      err_m = 0;
      if (!hv && mq.size() > 0) begin
        m_p = mq.pop_front();
        route(m_p, m_d, m_np);
        if (m_d == IND) err_m = 1;
        else begin hv = 1; hp = m_np; hd = m_d; end
      end
      if (m_push) mq.push_back(in_data);
      rdy_m = (mq.size() < D);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_out_valid", 64'(out_valid), hv ? 64'(5'b00001 << hd) : 64'd0);
      chk("m_in_ready", 64'(in_ready), 64'(rdy_m));
      chk("m_route_err", 64'(route_err), 64'(err_m));
      if (hv) chk("m_out_data", 64'(out_data), 64'(hp));
    end
  end

  logic [63:0] rnd;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_route_err", 64'(route_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 64'(in_ready), 64'd1);

    // straight east route with one-edge latency
    out_ready = 5'b11111; in_valid = 1'b1; in_data = pk(2'd0, 2'd0, 2'd2, 2'd0, 27'h1234567);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid", 64'(out_valid), 64'b00010);
    chk("t1_data", 64'(out_data), 64'({2'b01, 2'b00, 2'b10, 2'b00, 27'h1234567}));
    @(negedge clk);

    // PE delivery
    in_valid = 1'b1; in_data = pk(2'd1, 2'd3, 2'd1, 2'd3, 27'h7abcdef);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_valid", 64'(out_valid), 64'b10000);
    chk("t2_data", 64'(out_data), 64'({2'd1, 2'd3, 2'd1, 2'd3, 27'h7abcdef}));
    @(negedge clk);

    // back-to-back W then N
    in_valid = 1'b1; in_data = pk(2'd3, 2'd1, 2'd0, 2'd2, 27'h15);
    @(negedge clk);
    in_data = pk(2'd2, 2'd1, 2'd2, 2'd3, 27'h16);
    @(negedge clk);
    in_valid = 1'b0;
    chk("tw_valid", 64'(out_valid), 64'b01000);
    chk("tw_data", 64'(out_data), 64'({2'd2, 2'd1, 2'd0, 2'd2, 27'h15}));
    @(negedge clk);
    chk("tn_valid", 64'(out_valid), 64'b00001);
    chk("tn_data", 64'(out_data), 64'({2'd2, 2'd2, 2'd2, 2'd3, 27'h16}));
    @(negedge clk);

    // backpressure: 6 pushes, 1 held + 4 buffered, 6th refused
    out_ready = 5'b00000;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = pk(2'd0, 2'd0, 2'd3, 2'd0, 27'(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_valid", 64'(out_valid), 64'b00010);
    chk("bp_head", 64'(out_data), 64'(pk(2'd1, 2'd0, 2'd3, 2'd0, 27'd1)));
    out_ready = 5'b11101;
    @(negedge clk);
    chk("bp_other_ready_ignored", 64'(out_data), 64'(pk(2'd1, 2'd0, 2'd3, 2'd0, 27'd1)));
    out_ready = 5'b00010;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      chk("bp_drain", 64'(out_data), 64'(pk(2'd1, 2'd0, 2'd3, 2'd0, 27'(i))));
    end
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // two consecutive U-turns then a legal north packet
    out_ready = 5'b11111; in_valid = 1'b1; in_data = pk(2'd1, 2'd2, 2'd1, 2'd0, 27'h11);
    @(negedge clk);
    in_data = pk(2'd1, 2'd3, 2'd1, 2'd1, 27'h22);
    chk("ut_err0", 64'(route_err), 64'd0);
    @(negedge clk);
    in_data = pk(2'd1, 2'd0, 2'd1, 2'd2, 27'h33);
    chk("ut_err1", 64'(route_err), 64'd1);
    chk("ut_no_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ut_err2", 64'(route_err), 64'd1);
    @(negedge clk);
    chk("ut_err_clear", 64'(route_err), 64'd0);
    chk("ut_next_valid", 64'(out_valid), 64'b00001);
    chk("ut_next_data", 64'(out_data), 64'({2'd1, 2'd1, 2'd1, 2'd2, 27'h33}));
    @(negedge clk);

    // reset mid-stream with 1 held and 3 buffered
    out_ready = 5'b00000;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = pk(2'd0, 2'd0, 2'd3, 2'd0, 27'(8'h40 + i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mr_held", 64'(out_valid), 64'b00010);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd0);
    chk("mr_data", 64'(out_data), 64'd0);
    rst_n = 1'b1; out_ready = 5'b11111;
    @(negedge clk);
    chk("mr_ready_back", 64'(in_ready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      chk("mr_no_stale", 64'(out_valid), 64'd0);
    end

    // random traffic checked by the model
    repeat (300) begin
      rnd = {$urandom(), $urandom()};
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rnd[W-1:0];
      out_ready = 5'($urandom_range(0, 31));
      @(negedge clk);
    end
    in_valid = 1'b0;

`ifdef ROUTER_IN_PKT_CNT_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 5'b11111;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 2) ? pk(2'd2, 2'd2, 2'd2, 2'd1, 27'h5) : pk(2'd0, 2'd1, 2'd2, 2'd1, 27'(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("cnt_n", 64'(pkt_cnt[0 +: 16]), 64'd0);
    chk("cnt_e", 64'(pkt_cnt[16 +: 16]), 64'd3);
    chk("cnt_s", 64'(pkt_cnt[32 +: 16]), 64'd0);
    chk("cnt_w", 64'(pkt_cnt[48 +: 16]), 64'd0);
    chk("cnt_pe", 64'(pkt_cnt[64 +: 16]), 64'd0);
    chk("cnt_drop", 64'(drop_cnt), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
